// File: rtl/udp_depacketizer.sv
// Receive-side IQ-over-UDP depacketizer: filters fixed-format frames and writes {I,Q} words to the DAC FIFO.
// Optional macro SEQ_CHECK_EN enables sequence-gap accounting on lost_frames.
module udp_depacketizer #(
    parameter logic [47:0] LOCAL_MAC   = 48'h021234567890,
    parameter logic [31:0] LOCAL_IP    = {8'd10, 8'd0, 8'd0, 8'd2},
    parameter logic [15:0] LOCAL_PORT  = 16'd32179,
    parameter int          FRAME_BYTES = 1514,
    parameter int          HDR_BYTES   = 50
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_sop,
    input  logic        rx_eop,
    input  logic        rx_err,
    input  logic        rx_dval,
    output logic        rx_rdy,
    output logic        wr_en,
    output logic [31:0] wr_data,
    input  logic        wr_full,
    output logic [31:0] frames_ok,
    output logic [15:0] frames_dropped,
    output logic [15:0] overflow_cnt,
    output logic [15:0] lost_frames,
    output logic [63:0] last_seq
);

    localparam int IW = 11;
    localparam logic [IW-1:0] LAST_IDX  = IW'(FRAME_BYTES - 1);
    localparam logic [IW-1:0] HDR_LAST  = IW'(HDR_BYTES - 1);
    localparam logic [IW-1:0] SEQ_FIRST = IW'(HDR_BYTES - 8);

    typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, DROP} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [63:0]   seq_shadow_q, seq_shadow_d;
    logic [15:0]   i_q, i_d;
    logic [7:0]    q_lo_q, q_lo_d;
    logic [31:0]   wr_data_q, wr_data_d;
    logic          wr_pend_q, wr_pend_d;
    logic [31:0]   frames_ok_q, frames_ok_d;
    logic [15:0]   frames_dropped_q, frames_dropped_d;
    logic [15:0]   overflow_cnt_q, overflow_cnt_d;
    logic [63:0]   last_seq_q, last_seq_d;
    logic [1:0]    drop_inc;
    logic          good;
    logic [1:0]    lane;
    logic [2:0]    seq_slot;

    function automatic logic hdr_match(input logic [IW-1:0] idx, input logic [7:0] b);
        logic m;
        m = 1'b1;
        case (idx)
            11'd0:  m = (b == LOCAL_MAC[47:40]);
            11'd1:  m = (b == LOCAL_MAC[39:32]);
            11'd2:  m = (b == LOCAL_MAC[31:24]);
            11'd3:  m = (b == LOCAL_MAC[23:16]);
            11'd4:  m = (b == LOCAL_MAC[15:8]);
            11'd5:  m = (b == LOCAL_MAC[7:0]);
            11'd12: m = (b == 8'h08);
            11'd13: m = (b == 8'h00);
            11'd14: m = (b == 8'h45);
            11'd23: m = (b == 8'h11);
            11'd30: m = (b == LOCAL_IP[31:24]);
            11'd31: m = (b == LOCAL_IP[23:16]);
            11'd32: m = (b == LOCAL_IP[15:8]);
            11'd33: m = (b == LOCAL_IP[7:0]);
            11'd36: m = (b == LOCAL_PORT[15:8]);
            11'd37: m = (b == LOCAL_PORT[7:0]);
            11'd38: m = (b == 8'h05);
            11'd39: m = (b == 8'hC8);
            default: m = 1'b1;
        endcase
        return m;
    endfunction

    assign lane     = 2'(idx_q - IW'(HDR_BYTES));
    assign seq_slot = 3'(idx_q - SEQ_FIRST);

    always_comb begin
        state_d          = state_q;
        idx_d            = idx_q;
        seq_shadow_d     = seq_shadow_q;
        i_d              = i_q;
        q_lo_d           = q_lo_q;
        wr_data_d        = wr_data_q;
        wr_pend_d        = 1'b0;
        drop_inc         = 2'd0;
        good             = 1'b0;

        if (rx_dval) begin
            if (rx_sop) begin
                // A sop always restarts parsing; any frame in flight is abandoned as dropped.
                if (state_q != IDLE) drop_inc = drop_inc + 2'd1;
                if (rx_eop) begin
                    drop_inc = drop_inc + 2'd1;
                    state_d  = IDLE;
                    idx_d    = '0;
                end else begin
                    idx_d   = IW'(1);
                    state_d = hdr_match('0, rx_data) ? HEADER : DROP;
                end
            end else begin
                case (state_q)
                    HEADER: begin
                        idx_d = idx_q + IW'(1);
                        if (idx_q >= SEQ_FIRST) seq_shadow_d[{seq_slot, 3'b000} +: 8] = rx_data;
                        if (rx_eop) begin
                            drop_inc = 2'd1;
                            state_d  = IDLE;
                            idx_d    = '0;
                        end else if (!hdr_match(idx_q, rx_data)) begin
                            state_d = DROP;
                        end else if (idx_q == HDR_LAST) begin
                            state_d = PAYLOAD;
                        end
                    end
                    PAYLOAD: begin
                        idx_d = idx_q + IW'(1);
                        case (lane)
                            2'd0: i_d[7:0]  = rx_data;
                            2'd1: i_d[15:8] = rx_data;
                            2'd2: q_lo_d    = rx_data;
                            default: begin
                                wr_data_d = {i_q, rx_data, q_lo_q};
                                wr_pend_d = 1'b1;
                            end
                        endcase
                        if (idx_q == LAST_IDX) begin
                            if (!rx_eop) begin
                                state_d = DROP;
                            end else begin
                                state_d = IDLE;
                                idx_d   = '0;
                                if (rx_err) drop_inc = 2'd1;
                                else        good     = 1'b1;
                            end
                        end else if (rx_eop) begin
                            drop_inc = 2'd1;
                            state_d  = IDLE;
                            idx_d    = '0;
                        end
                    end
                    DROP: begin
                        if (rx_eop) begin
                            drop_inc = 2'd1;
                            state_d  = IDLE;
                            idx_d    = '0;
                        end
                    end
                    default: ;
                endcase
            end
        end

        frames_ok_d      = frames_ok_q + 32'(good);
        frames_dropped_d = frames_dropped_q + 16'(drop_inc);
        overflow_cnt_d   = overflow_cnt_q + 16'(wr_pend_q & wr_full);
        last_seq_d       = good ? seq_shadow_q : last_seq_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            idx_q            <= '0;
            seq_shadow_q     <= '0;
            i_q              <= '0;
            q_lo_q           <= '0;
            wr_data_q        <= '0;
            wr_pend_q        <= 1'b0;
            frames_ok_q      <= '0;
            frames_dropped_q <= '0;
            overflow_cnt_q   <= '0;
            last_seq_q       <= '0;
        end else begin
            state_q          <= state_d;
            idx_q            <= idx_d;
            seq_shadow_q     <= seq_shadow_d;
            i_q              <= i_d;
            q_lo_q           <= q_lo_d;
            wr_data_q        <= wr_data_d;
            wr_pend_q        <= wr_pend_d;
            frames_ok_q      <= frames_ok_d;
            frames_dropped_q <= frames_dropped_d;
            overflow_cnt_q   <= overflow_cnt_d;
            last_seq_q       <= last_seq_d;
        end
    end

`ifdef SEQ_CHECK_EN
    logic [15:0] lost_frames_q, lost_frames_d;
    logic        have_seq_q, have_seq_d;

    // The first good frame after reset only seeds last_seq; later gaps accumulate modulo 2^16.
    always_comb begin
        lost_frames_d = lost_frames_q;
        have_seq_d    = have_seq_q | good;
        if (good && have_seq_q && (seq_shadow_q != last_seq_q + 64'd1))
            lost_frames_d = lost_frames_q + 16'(seq_shadow_q[15:0] - last_seq_q[15:0] - 16'd1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lost_frames_q <= '0;
            have_seq_q    <= 1'b0;
        end else begin
            lost_frames_q <= lost_frames_d;
            have_seq_q    <= have_seq_d;
        end
    end

    assign lost_frames = lost_frames_q;
`else
    assign lost_frames = '0;
`endif

    assign rx_rdy         = ~rst;
    assign wr_en          = wr_pend_q & ~wr_full;
    assign wr_data        = wr_data_q;
    assign frames_ok      = frames_ok_q;
    assign frames_dropped = frames_dropped_q;
    assign overflow_cnt   = overflow_cnt_q;
    assign last_seq       = last_seq_q;

endmodule

// File: doc/udp_depacketizer.md
Name: udp_depacketizer

Overview:
- Receive-side counterpart of the IQ-over-UDP transmit path.
- Accepts bytes from the Ethernet MAC RX interface and filters for fixed-format IQ frames addressed to this node.
- Extracts 32-bit {I,Q} sample words and writes them into the Serializer-side FIFO that feeds the DAC path.
- Exposes frame, drop and overflow statistics to the control registers.

Parameters:
- LOCAL_MAC, 48'h021234567890: destination MAC accepted.
- LOCAL_IP, {8'd10,8'd0,8'd0,8'd2}: destination IP accepted.
- LOCAL_PORT, 16'd32179: destination UDP port accepted.
- FRAME_BYTES, 1514: exact frame length, bytes 0..FRAME_BYTES-1, FCS excluded.
- HDR_BYTES, 50: bytes before first IQ byte, including the 8-byte sequence field at offsets 42..49.

Ports:
- clk  in  1  single clock; MAC rx_clk and FIFO write clock.
- rst  in  1  synchronous, active-high reset.
- rx_data  in  8  MAC RX byte.
- rx_sop  in  1  first byte of frame, qualified by rx_dval.
- rx_eop  in  1  last byte of frame, qualified by rx_dval.
- rx_err  in  1  frame error, sampled with rx_eop.
- rx_dval  in  1  byte valid.
- rx_rdy  out  1  ready to MAC.
- wr_en  out  1  FIFO write strobe.
- wr_data  out  32  {I[15:0],Q[15:0]}.
- wr_full  in  1  FIFO full.
- frames_ok  out  32  count of valid frames.
- frames_dropped  out  16  count of filtered, runt, oversize or errored frames.
- overflow_cnt  out  16  count of samples lost to wr_full.
- lost_frames  out  16  count of sequence gaps.
- last_seq  out  64  sequence number of the last good frame.

Behaviour:
- Reset values: all outputs 0, state IDLE, byte index 0.
- rx_rdy is 1 in every cycle rst is low. The block never back-pressures the MAC.
- A byte is consumed only when rx_dval=1. Byte index increments per consumed byte.
- States:
  - IDLE: wait for rx_sop & rx_dval; the byte is index 0; go to HEADER.
  - HEADER: compare each byte against the expected value at its offset:
    - 0-5: LOCAL_MAC, MSB first.
    - 12-13: 08 00.
    - 14: 45.
    - 23: 11.
    - 30-33: LOCAL_IP.
    - 36-37: LOCAL_PORT.
    - 38-39: 05 C8.
    - Other offsets are don't-care; IP and UDP checksums are not checked.
    - Any mismatch goes to DROP.
    - Bytes 42..49 form the sequence number, little-endian, staged in a shadow register.
    - Byte 49 consumed goes to PAYLOAD.
  - PAYLOAD: bytes arrive as I[7:0], I[15:8], Q[7:0], Q[15:8], repeating.
    - Cycle after the Q[15:8] byte is consumed: wr_en=1 for exactly one cycle with wr_data={I,Q}.
    - If wr_full=1 in that cycle: wr_en stays 0 and overflow_cnt increments.
    - Byte FRAME_BYTES-1 with rx_eop=1 and rx_err=0: frame is good.
      - frames_ok increments.
      - last_seq loads the shadow sequence.
      - Go to IDLE.
  - DROP: discard bytes until rx_eop; frames_dropped increments once per frame; go to IDLE.
- Boundary cases:
  - rx_eop before byte FRAME_BYTES-1 (runt): frames_dropped increments, go to IDLE. Samples already written are not retracted.
  - Byte FRAME_BYTES-1 without rx_eop (oversize): go to DROP. The frame is not counted good.
  - rx_err=1 with rx_eop: frame dropped even at correct length. Samples already written stand.
  - rx_sop in HEADER, PAYLOAD or DROP: current frame counted dropped; the sop byte restarts parsing at index 0.
  - rx_sop and rx_eop on the same byte: frames_dropped increments; stay in IDLE.
  - Bytes with rx_dval=1 in IDLE without rx_sop: ignored.
  - rst mid-frame: immediate return to IDLE and all counters cleared. Remaining bytes of that frame are ignored until the next rx_sop.
- Counters wrap modulo 2^width.
- 366 samples per good frame.

Optional Feature:
- Macro SEQ_CHECK_EN.
- When defined:
  - On each good frame after the first good frame since reset, if the new sequence != last_seq+1 (64-bit wrap), lost_frames += new - last_seq - 1, truncated to 16 bits.
  - The first good frame after reset only initialises last_seq.
- When undefined: lost_frames tied to 0; sequence is still captured into last_seq.

Test Plan:
- One well-formed 1514-byte frame, seq=0, samples k={k,~k}, wr_full=0 -> 366 wr_en pulses in order, frames_ok=1, last_seq=0, other counters 0.
- Same frame with dest port 32180 -> no wr_en, frames_dropped=1; next valid frame is accepted, frames_ok=1.
- Frames seq 5, 6, 9 with SEQ_CHECK_EN -> lost_frames=2, last_seq=9; without the macro -> lost_frames=0, last_seq=9.
- wr_full held 1 during samples 10..19 of a good frame -> 356 writes, overflow_cnt=10, frames_ok=1.
- rx_eop at byte 800, then rx_sop mid-frame at byte 300 of the following frame -> frames_dropped=2; third, valid frame gives frames_ok=1.
- rst asserted at byte 600, released, then a valid frame -> all counters 0 after reset, frames_ok=1 after the frame, no spurious wr_en from the aborted frame.
